// File: rtl/gate_model_bist.sv
// BIST controller: LFSR patterns out, MISR compaction of model responses,
// golden-signature compare reported through a start/busy/done handshake.
module gate_model_bist #(
  parameter int          IN_W      = 17,
  parameter int          OUT_W     = 9,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_POLY = 32'h0001_0003,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter logic [31:0] MISR_POLY = 32'h0000_0011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [OUT_W-1:0] expected_sig,
  output logic [IN_W-1:0]  pat_out,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [IN_W-1:0] SEED_RAW = LFSR_SEED[IN_W-1:0];
  localparam logic [IN_W-1:0] SEED =
    (SEED_RAW == '0) ? IN_W'(1) : SEED_RAW;
  localparam logic [IN_W-1:0]  LPOLY = LFSR_POLY[IN_W-1:0];
  localparam logic [OUT_W-1:0] MPOLY = MISR_POLY[OUT_W-1:0];

  state_t             state_q, state_d;
  logic [IN_W-1:0]    pat_q, pat_d;
  logic [OUT_W-1:0]   misr_q, misr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [OUT_W-1:0]   exp_q, exp_d;
  logic [OUT_W-1:0]   sig_q, sig_d;
  logic               pass_q, pass_d;
  logic [IN_W-1:0]    lfsr_nxt;
  logic [OUT_W-1:0]   misr_nxt;

  always_comb begin
    lfsr_nxt = {pat_q[IN_W-2:0], 1'b0}
             ^ (pat_q[IN_W-1] ? LPOLY : '0);
    misr_nxt = {misr_q[OUT_W-2:0], 1'b0}
             ^ (misr_q[OUT_W-1] ? MPOLY : '0)
             ^ resp_in;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d  = num_patterns;
          exp_d  = expected_sig;
          pat_d  = SEED;
          misr_d = '0;
          cnt_d  = '0;
          sig_d  = '0;
          pass_d = 1'b0;
          if (num_patterns == '0) begin
            // empty run: result is an all-zero MISR
            state_d = S_FIN;
            pass_d  = (expected_sig == '0);
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        pat_d  = lfsr_nxt;
        misr_d = misr_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == num_q - CNT_W'(1)) begin
          // result registered here so it is valid with done
          state_d = S_FIN;
          sig_d   = misr_nxt;
          pass_d  = (misr_nxt == exp_q);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign pat_out   = pat_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_gate_model_bist.sv
// Directed bench: 4/4 instance for sequence and handshake cases,
// default 17/9 instance driving a small gate model with fault injection.
module tb_gate_model_bist;

  logic clk;
  logic rst_n;

  logic        s_start;
  logic [15:0] s_n;
  logic [3:0]  s_exp;
  logic [3:0]  s_pat;
  logic [3:0]  s_resp;
  logic        s_busy, s_done, s_pass;
  logic [3:0]  s_sig;
  logic        loop4;

  logic        d_start;
  logic [15:0] d_n;
  logic [8:0]  d_exp;
  logic [16:0] d_pat;
  logic [8:0]  d_resp;
  logic        d_busy, d_done, d_pass;
  logic [8:0]  d_sig;
  logic        fault;

  int checks;
  int failures;

  gate_model_bist #(
    .IN_W(4), .OUT_W(4), .CNT_W(16),
    .LFSR_POLY(32'h3), .LFSR_SEED(32'h1),
    .MISR_POLY(32'h3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .num_patterns(s_n), .expected_sig(s_exp),
    .pat_out(s_pat), .resp_in(s_resp),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .signature(s_sig)
  );

  gate_model_bist u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start),
    .num_patterns(d_n), .expected_sig(d_exp),
    .pat_out(d_pat), .resp_in(d_resp),
    .busy(d_busy), .done(d_done), .pass(d_pass),
    .signature(d_sig)
  );

  // 17-in/9-out gate model; fault turns one AND gate into an OR
  function automatic logic [8:0] gm(
    input logic [16:0] a, input logic f);
    logic [8:0] o;
    o[0] = a[0] ^ a[1] ^ a[2];
    o[1] = (f ? (a[3] | a[4]) : (a[3] & a[4])) | a[5];
    o[2] = ~(a[6] & a[7]);
    o[3] = a[8] ^ (a[9] & a[10]);
    o[4] = (a[11] | a[12]) & a[13];
    o[5] = a[14] ^ a[15] ^ a[16];
    o[6] = (a[0] & a[16]) ^ a[8];
    o[7] = ~(a[2] | a[9]) ^ a[13];
    o[8] = (a[5] & a[6]) | (a[11] ^ a[15]);
    return o;
  endfunction

  function automatic logic [8:0] ref_sig(
    input int n, input logic f);
    logic [16:0] p;
    logic [8:0]  m;
    p = 17'h1;
    m = 9'h0;
    for (int i = 0; i < n; i++) begin
      m = {m[7:0], 1'b0} ^ (m[8] ? 9'h011 : 9'h0)
        ^ gm(p, f);
      p = {p[15:0], 1'b0} ^ (p[16] ? 17'h1_0003 : 17'h0);
    end
    return m;
  endfunction

  always_comb s_resp = loop4 ? s_pat : 4'h0;
  always_comb d_resp = gm(d_pat, fault);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  logic [3:0]  lfsr_tab [16];
  logic [3:0]  held_tab [5];
  logic [8:0]  golden;
  logic [8:0]  bad_sig;
  int          bcnt;
  logic        seen;

  initial begin
    lfsr_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6,
                 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE,
                 4'hF, 4'hD, 4'h9, 4'h1};
    held_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    s_start = 1'b0; s_n = '0; s_exp = '0; loop4 = 1'b0;
    d_start = 1'b0; d_n = '0; d_exp = '0; fault = 1'b0;
    #12;
    chk("rst_pat", 32'(s_pat), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_pass", 32'(s_pass), 0);
    chk("rst_sig", 32'(s_sig), 0);
    chk("rst_dpat", 32'(d_pat), 0);
    chk("rst_dsig", 32'(d_sig), 0);
    rst_n = 1'b1;
    tick();

    // LFSR sequence, N=16, zero responses
    s_n = 16'd16; s_exp = 4'h0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lfsr_pat%0d", i), 32'(s_pat),
          32'(lfsr_tab[i]));
      chk($sformatf("lfsr_busy%0d", i), 32'(s_busy), 1);
      chk($sformatf("lfsr_done%0d", i), 32'(s_done), 0);
      tick();
    end
    chk("lfsr_fin_done", 32'(s_done), 1);
    chk("lfsr_fin_busy", 32'(s_busy), 0);
    chk("lfsr_sig", 32'(s_sig), 0);
    chk("lfsr_pass", 32'(s_pass), 1);
    tick();
    chk("lfsr_done_once", 32'(s_done), 0);
    chk("lfsr_pass_hold", 32'(s_pass), 1);

    // MISR loopback, N=3, golden 4
    loop4 = 1'b1; s_n = 16'd3; s_exp = 4'h4; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("misr_pass_clr", 32'(s_pass), 0);
    tick(); tick(); tick();
    chk("misr_done", 32'(s_done), 1);
    chk("misr_sig", 32'(s_sig), 4);
    chk("misr_pass", 32'(s_pass), 1);
    tick();
    s_exp = 4'h5; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_exp = 4'h4;
    tick(); tick(); tick();
    chk("misr2_done", 32'(s_done), 1);
    chk("misr2_sig", 32'(s_sig), 4);
    chk("misr2_pass", 32'(s_pass), 0);
    tick();

    // N=0
    loop4 = 1'b0; s_n = 16'd0; s_exp = 4'h0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("n0_done", 32'(s_done), 1);
    chk("n0_busy", 32'(s_busy), 0);
    chk("n0_sig", 32'(s_sig), 0);
    chk("n0_pass", 32'(s_pass), 1);
    tick();
    chk("n0_done_end", 32'(s_done), 0);
    chk("n0_busy_end", 32'(s_busy), 0);

    // reset during 5th RUN cycle of N=10
    s_n = 16'd10; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_busy_pre", 32'(s_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_pat", 32'(s_pat), 0);
    chk("mid_busy", 32'(s_busy), 0);
    chk("mid_done", 32'(s_done), 0);
    chk("mid_pass", 32'(s_pass), 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mid_nodone%0d", i), 32'(s_done), 0);
    end
    s_n = 16'd3; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_busy%0d", i), 32'(s_busy), 1);
      tick();
    end
    chk("post_done", 32'(s_done), 1);
    chk("post_sig", 32'(s_sig), 0);
    chk("post_pass", 32'(s_pass), 1);
    tick();

    // start held high through a loopback run, N=5
    loop4 = 1'b1; s_n = 16'd5; s_exp = 4'h3; s_start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("held_pat%0d", i), 32'(s_pat),
          32'(held_tab[i]));
      chk($sformatf("held_busy%0d", i), 32'(s_busy), 1);
      tick();
    end
    chk("held_done", 32'(s_done), 1);
    chk("held_sig", 32'(s_sig), 3);
    chk("held_pass", 32'(s_pass), 1);
    tick();
    chk("held_idle_done", 32'(s_done), 0);
    chk("held_idle_busy", 32'(s_busy), 0);
    chk("held_idle_sig", 32'(s_sig), 3);
    tick();
    s_start = 1'b0;
    chk("held_rerun_busy", 32'(s_busy), 1);
    chk("held_rerun_pat", 32'(s_pat), 1);
    chk("held_rerun_sig", 32'(s_sig), 0);
    chk("held_rerun_pass", 32'(s_pass), 0);
    tick(); tick(); tick(); tick(); tick();
    chk("held_rerun_done", 32'(s_done), 1);
    chk("held_rerun_sig2", 32'(s_sig), 3);
    tick();

    // default 17/9 with gate model
    golden = ref_sig(1000, 1'b0);
    bad_sig = ref_sig(1000, 1'b1);
    for (int r = 0; r < 2; r++) begin
      fault = (r == 1);
      d_n = 16'd1000; d_exp = golden; d_start = 1'b1;
      tick();
      d_start = 1'b0;
      bcnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 1100 && !seen; c++) begin
        if (d_busy) bcnt++;
        if (d_done) seen = 1'b1;
        else tick();
      end
      chk($sformatf("gm%0d_done_seen", r), 32'(seen), 1);
      chk($sformatf("gm%0d_busy_cnt", r), 32'(bcnt), 1000);
      chk($sformatf("gm%0d_sig", r), 32'(d_sig),
          32'(r == 1 ? bad_sig : golden));
      chk($sformatf("gm%0d_pass", r), 32'(d_pass),
          32'(r == 1 ? (bad_sig == golden) : 1'b1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
